// File: rtl/ex_stage.sv
// RV32I execute stage: integer ALU for the OP-IMM and OP opcode classes, followed by a
// single register stage that feeds writeback.
module ex_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] inst_i,
    input  logic [4:0]  reg_waddr_i,
    input  logic [31:0] op1_i,
    input  logic [31:0] op2_i,
    output logic [31:0] reg_wdata_o,
    output logic [4:0]  reg_waddr_o,
    output logic        reg_we_o
);

    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    typedef enum logic [2:0] {
        F3_ADD  = 3'b000,
        F3_SLL  = 3'b001,
        F3_SLT  = 3'b010,
        F3_SLTU = 3'b011,
        F3_XOR  = 3'b100,
        F3_SR   = 3'b101,
        F3_OR   = 3'b110,
        F3_AND  = 3'b111
    } funct3_e;

    logic [6:0]  opcode;
    funct3_e     funct3;
    logic        alt;
    logic        is_op;
    logic        is_op_imm;
    logic [4:0]  shamt;

    logic [31:0] reg_wdata_d, reg_wdata_q;
    logic [4:0]  reg_waddr_q;
    logic        reg_we_d, reg_we_q;

    assign opcode    = inst_i[6:0];
    assign funct3    = funct3_e'(inst_i[14:12]);
    assign alt       = inst_i[30];
    assign is_op     = (opcode == OPC_OP);
    assign is_op_imm = (opcode == OPC_OP_IMM);
    // Immediate shifts take the amount from the instruction, register shifts from rs2.
    assign shamt     = is_op ? op2_i[4:0] : inst_i[24:20];

    always_comb begin
        // NOTE: defaults first so every path assigns both signals and no latch is inferred.
        reg_wdata_d = '0;
        reg_we_d    = 1'b0;
        if (is_op || is_op_imm) begin
            reg_we_d = 1'b1;
            case (funct3)
                F3_ADD:  reg_wdata_d = (is_op && alt) ? op1_i - op2_i : op1_i + op2_i;
                F3_SLL:  reg_wdata_d = op1_i << shamt;
                F3_SLT:  reg_wdata_d = {31'b0, $signed(op1_i) < $signed(op2_i)};
                F3_SLTU: reg_wdata_d = {31'b0, op1_i < op2_i};
                F3_XOR:  reg_wdata_d = op1_i ^ op2_i;
                F3_SR:   reg_wdata_d = alt ? 32'($signed(op1_i) >>> shamt) : op1_i >> shamt;
                F3_OR:   reg_wdata_d = op1_i | op2_i;
                F3_AND:  reg_wdata_d = op1_i & op2_i;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers sample together.
    always_ff @(posedge clk) begin
        if (rst) begin
            reg_wdata_q <= '0;
            reg_waddr_q <= '0;
            reg_we_q    <= 1'b0;
        end else begin
            reg_wdata_q <= reg_wdata_d;
            reg_waddr_q <= reg_waddr_i;
            reg_we_q    <= reg_we_d;
        end
    end

    assign reg_wdata_o = reg_wdata_q;
    assign reg_waddr_o = reg_waddr_q;
    assign reg_we_o    = reg_we_q;

endmodule

// File: tb/tb_ex_stage.sv
// Directed-vector bench for ex_stage: each feature task drives instructions and checks
// the registered outputs one clock later against hand-computed values.
module tb_ex_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] inst_i;
    logic [4:0]  reg_waddr_i;
    logic [31:0] op1_i;
    logic [31:0] op2_i;
    logic [31:0] reg_wdata_o;
    logic [4:0]  reg_waddr_o;
    logic        reg_we_o;

    int vectors     = 0;
    int miscompares = 0;

    typedef struct {
        string       name;
        logic [31:0] inst;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        logic        we;
    } vec_t;

    ex_stage dut (
        .clk         (clk),
        .rst         (rst),
        .inst_i      (inst_i),
        .reg_waddr_i (reg_waddr_i),
        .op1_i       (op1_i),
        .op2_i       (op2_i),
        .reg_wdata_o (reg_wdata_o),
        .reg_waddr_o (reg_waddr_o),
        .reg_we_o    (reg_we_o)
    );

    always #5 clk = ~clk;

    task automatic drive(input logic [31:0] inst, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] wa);
        inst_i      = inst;
        op1_i       = a;
        op2_i       = b;
        reg_waddr_i = wa;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        vec_t v [2] = '{
            '{"ADDI", 32'hfff08013, 32'h42, 32'h69, 32'h000000ab, 1'b1},
            '{"SUB",  32'h40208033, 32'h42, 32'h69, 32'hffffffd9, 1'b1}
        };
        rst = 1'b1;
        drive(32'hfff08013, 32'h42, 32'h69, 5'd3);
        step();
        step();
        vectors++;
        if (reg_wdata_o !== 32'h0 || reg_waddr_o !== 5'd0 || reg_we_o !== 1'b0) begin
            miscompares++;
            $display("FAIL reset: wdata=%h waddr=%0d we=%b, expected 0/0/0",
                     reg_wdata_o, reg_waddr_o, reg_we_o);
        end
        rst = 1'b0;
        for (int i = 0; i < 2; i++) begin
            drive(v[i].inst, v[i].a, v[i].b, 5'd3);
            step();
            vectors++;
            if (reg_wdata_o !== v[i].exp || reg_waddr_o !== 5'd3 || reg_we_o !== v[i].we) begin
                miscompares++;
                $display("FAIL %s: wdata=%h waddr=%0d we=%b, expected %h/3/%b",
                         v[i].name, reg_wdata_o, reg_waddr_o, reg_we_o, v[i].exp, v[i].we);
            end
        end
    endtask

    task automatic test_compare_logic();
        vec_t v [5] = '{
            '{"SLTI",  32'h0021a113, 32'h42, 32'h69, 32'h00000001, 1'b1},
            '{"SLTIU", 32'hffd2b213, 32'h42, 32'h69, 32'h00000001, 1'b1},
            '{"XORI",  32'h0043c313, 32'h42, 32'h69, 32'h0000002b, 1'b1},
            '{"ORI",   32'hffb4e413, 32'h42, 32'h69, 32'h0000006b, 1'b1},
            '{"ANDI",  32'h0065f513, 32'h42, 32'h69, 32'h00000040, 1'b1}
        };
        for (int i = 0; i < 5; i++) begin
            drive(v[i].inst, v[i].a, v[i].b, 5'd3);
            step();
            vectors++;
            if (reg_wdata_o !== v[i].exp || reg_waddr_o !== 5'd3 || reg_we_o !== v[i].we) begin
                miscompares++;
                $display("FAIL %s: wdata=%h waddr=%0d we=%b, expected %h/3/%b",
                         v[i].name, reg_wdata_o, reg_waddr_o, reg_we_o, v[i].exp, v[i].we);
            end
        end
    endtask

    task automatic test_compare_boundaries();
        vec_t v [6] = '{
            '{"SLT_min",   32'h00002033, 32'h80000000, 32'h0,  32'h1, 1'b1},
            '{"SLTU_min",  32'h00003033, 32'h80000000, 32'h0,  32'h0, 1'b1},
            '{"SLTI_min",  32'h00002013, 32'h80000000, 32'h0,  32'h1, 1'b1},
            '{"SLTIU_min", 32'h00003013, 32'h80000000, 32'h0,  32'h0, 1'b1},
            '{"SLT_eq",    32'h00002033, 32'h55,       32'h55, 32'h0, 1'b1},
            '{"SLTU_eq",   32'h00003033, 32'h55,       32'h55, 32'h0, 1'b1}
        };
        for (int i = 0; i < 6; i++) begin
            drive(v[i].inst, v[i].a, v[i].b, 5'd3);
            step();
            vectors++;
            if (reg_wdata_o !== v[i].exp || reg_waddr_o !== 5'd3 || reg_we_o !== v[i].we) begin
                miscompares++;
                $display("FAIL %s: wdata=%h waddr=%0d we=%b, expected %h/3/%b",
                         v[i].name, reg_wdata_o, reg_waddr_o, reg_we_o, v[i].exp, v[i].we);
            end
        end
    endtask

    task automatic test_imm_shifts();
        vec_t v [6] = '{
            '{"SLLI",       32'h00769613, 32'h42,       32'h69, 32'h00002100, 1'b1},
            '{"SRLI",       32'h0017d713, 32'h42,       32'h69, 32'h00000021, 1'b1},
            '{"SRAI",       32'h4018d813, 32'h42,       32'h69, 32'h00000021, 1'b1},
            '{"SRAI_neg",   32'h4018d813, 32'h80000000, 32'h69, 32'hc0000000, 1'b1},
            '{"SLLI_zero",  32'h00001013, 32'hdeadbeef, 32'h69, 32'hdeadbeef, 1'b1},
            '{"SRAI_zero",  32'h40005013, 32'hdeadbeef, 32'h69, 32'hdeadbeef, 1'b1}
        };
        for (int i = 0; i < 6; i++) begin
            drive(v[i].inst, v[i].a, v[i].b, 5'd3);
            step();
            vectors++;
            if (reg_wdata_o !== v[i].exp || reg_waddr_o !== 5'd3 || reg_we_o !== v[i].we) begin
                miscompares++;
                $display("FAIL %s: wdata=%h waddr=%0d we=%b, expected %h/3/%b",
                         v[i].name, reg_wdata_o, reg_waddr_o, reg_we_o, v[i].exp, v[i].we);
            end
        end
    endtask

    task automatic test_register_ops();
        vec_t v [4] = '{
            '{"SLL",      32'h00209033, 32'h42,       32'h69, 32'h00008400, 1'b1},
            '{"SRL",      32'h00005033, 32'h80000000, 32'h24, 32'h08000000, 1'b1},
            '{"SRA",      32'h40005033, 32'h80000000, 32'h24, 32'hf8000000, 1'b1},
            '{"ADD_wrap", 32'h00000033, 32'hffffffff, 32'h2,  32'h00000001, 1'b1}
        };
        for (int i = 0; i < 4; i++) begin
            drive(v[i].inst, v[i].a, v[i].b, 5'd3);
            step();
            vectors++;
            if (reg_wdata_o !== v[i].exp || reg_waddr_o !== 5'd3 || reg_we_o !== v[i].we) begin
                miscompares++;
                $display("FAIL %s: wdata=%h waddr=%0d we=%b, expected %h/3/%b",
                         v[i].name, reg_wdata_o, reg_waddr_o, reg_we_o, v[i].exp, v[i].we);
            end
        end
    endtask

    task automatic test_unsupported_and_mid_reset();
        vec_t v [2] = '{
            '{"SYSTEM", 32'h00000073, 32'h42, 32'h69, 32'h0, 1'b0},
            '{"bubble", 32'h00000000, 32'h42, 32'h69, 32'h0, 1'b0}
        };
        for (int i = 0; i < 2; i++) begin
            drive(v[i].inst, v[i].a, v[i].b, 5'd3);
            step();
            vectors++;
            if (reg_wdata_o !== v[i].exp || reg_waddr_o !== 5'd3 || reg_we_o !== v[i].we) begin
                miscompares++;
                $display("FAIL %s: wdata=%h waddr=%0d we=%b, expected %h/3/%b",
                         v[i].name, reg_wdata_o, reg_waddr_o, reg_we_o, v[i].exp, v[i].we);
            end
        end
        drive(32'hfff08013, 32'h42, 32'h69, 5'd3);
        rst = 1'b1;
        step();
        vectors++;
        if (reg_wdata_o !== 32'h0 || reg_waddr_o !== 5'd0 || reg_we_o !== 1'b0) begin
            miscompares++;
            $display("FAIL mid_reset: wdata=%h waddr=%0d we=%b, expected 0/0/0",
                     reg_wdata_o, reg_waddr_o, reg_we_o);
        end
        rst = 1'b0;
        step();
        vectors++;
        if (reg_wdata_o !== 32'hab || reg_waddr_o !== 5'd3 || reg_we_o !== 1'b1) begin
            miscompares++;
            $display("FAIL post_reset_ADDI: wdata=%h waddr=%0d we=%b, expected ab/3/1",
                     reg_wdata_o, reg_waddr_o, reg_we_o);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] ins [4] = '{32'hfff08013, 32'h40208033, 32'h0043c313, 32'h00209033};
        logic [31:0] exp [4] = '{32'h000000ab, 32'hffffffd9, 32'h0000002b, 32'h00008400};
        logic [4:0]  wa  [4] = '{5'd7, 5'd12, 5'd31, 5'd1};
        for (int i = 0; i < 4; i++) begin
            drive(ins[i], 32'h42, 32'h69, wa[i]);
            #2;
            if (i > 0) begin
                vectors++;
                if (reg_wdata_o !== exp[i-1] || reg_waddr_o !== wa[i-1]) begin
                    miscompares++;
                    $display("FAIL b2b_hold[%0d]: wdata=%h waddr=%0d, expected %h/%0d before edge",
                             i, reg_wdata_o, reg_waddr_o, exp[i-1], wa[i-1]);
                end
            end
            step();
            vectors++;
            if (reg_wdata_o !== exp[i] || reg_waddr_o !== wa[i] || reg_we_o !== 1'b1) begin
                miscompares++;
                $display("FAIL b2b[%0d]: wdata=%h waddr=%0d we=%b, expected %h/%0d/1",
                         i, reg_wdata_o, reg_waddr_o, reg_we_o, exp[i], wa[i]);
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        drive(32'h0, 32'h0, 32'h0, 5'd0);
        #1;
        test_reset();
        test_compare_logic();
        test_compare_boundaries();
        test_imm_shifts();
        test_register_ops();
        test_unsupported_and_mid_reset();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
